// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Quotient returned for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: request/operands in, stall request and results out.
interface div_unit_if #(
  parameter int WIDTH = div_unit_pkg::DIV_WIDTH
);
  logic             div_req;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             annul;
  logic             stallreq_for_ex;
  logic             div_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_req, div_signed, dividend, divisor, annul,
    input  stallreq_for_ex, div_ready, quotient, remainder
  );

  modport slave (
    input  div_req, div_signed, dividend, divisor, annul,
    output stallreq_for_ex, div_ready, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic             sub_ok;

  // Shift the next dividend bit into the partial remainder, subtract if it fits.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign sub_ok  = (shifted >= {2'b00, dvs_i});
  assign rem_o   = sub_ok ? (shifted[WIDTH:0] - {1'b0, dvs_i}) : shifted[WIDTH:0];
  assign quo_o   = {quo_i[WIDTH-2:0], sub_ok};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU; stalls the pipeline until the
// result is ready and returns quotient (LO) and remainder (HI).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, rem_step;
  logic [WIDTH-1:0] quo_q, quo_d, quo_step;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_ready;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (bus.annul) begin
      // Flush wins over everything; result registers keep stale data.
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.div_req) begin
            dvd_d     = bus.dividend;
            quo_d     = magnitude(bus.dividend, bus.div_signed);
            dvs_d     = magnitude(bus.divisor, bus.div_signed);
            rem_d     = '0;
            quo_neg_d = bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            rem_neg_d = bus.div_signed & bus.dividend[WIDTH-1];
            cnt_d     = '0;
            state_d   = (bus.divisor == '0) ? DIV_ZERO : DIV_RUN;
          end
        end
        DIV_ZERO: begin
          quotient_d  = WIDTH'(DIV_ZERO_QUOT);
          remainder_d = dvd_q;
          state_d     = DIV_DONE;
        end
        DIV_RUN: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quotient_d  = quo_neg_q ? -quo_step : quo_step;
            remainder_d = rem_neg_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
            cnt_d       = '0;
            state_d     = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!bus.div_req) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_ready           = (state_q == DIV_DONE);
  assign bus.div_ready       = div_ready;
  assign bus.quotient        = quotient_q;
  assign bus.remainder       = remainder_q;
  assign bus.stallreq_for_ex = bus.div_req & ~div_ready & ~bus.annul;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, abort/reset sequences, random divides.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] last_q, last_r;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline is frozen while a divide runs; EX may only leave via a flush.
  a_no_req_drop: assert property (@(posedge clk) disable iff (!rst)
    (dut.state_q inside {DIV_RUN, DIV_ZERO}) |-> (bus.div_req || bus.annul))
    else $error("div_req dropped while a divide was in progress");

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with truncation toward zero.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endtask

  // Entered at cycle 0 with the unit idle; leaves after a one-cycle div_req gap.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input int hold);
    int exp_lat, lat, stall_cnt;
    exp_lat   = (b == 32'd0) ? 2 : 33;
    lat       = 0;
    stall_cnt = 0;
    bus.div_req    = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.annul      = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.div_ready || lat >= 40) break;
      if (bus.stallreq_for_ex) stall_cnt++;
      next_cycle();
      lat++;
      // Operands are only valid in the request cycle.
      bus.dividend   = $urandom;
      bus.divisor    = $urandom;
      bus.div_signed = 1'($urandom);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
    check({name, " stall in DONE"}, 32'(bus.stallreq_for_ex), 32'd0);
    check({name, " quotient"}, bus.quotient, eq);
    check({name, " remainder"}, bus.remainder, er);
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      @(negedge clk);
      check({name, " hold ready"}, 32'(bus.div_ready), 32'd1);
      check({name, " hold quotient"}, bus.quotient, eq);
      check({name, " hold remainder"}, bus.remainder, er);
    end
    next_cycle();
    bus.div_req = 1'b0;
    next_cycle();
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        sgn;
    n_vec = 0;
    n_err = 0;

    tbl[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    tbl[4]  = '{32'd1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'd1234};
    tbl[5]  = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234};
    tbl[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    tbl[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
    tbl[8]  = '{32'd5,          32'h8000_0000,  1'b0, 32'd0,          32'd5};
    tbl[9]  = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0};
    tbl[10] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    tbl[11] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE};

    rst            = 1'b0;
    bus.div_req    = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.annul      = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset ready", 32'(bus.div_ready), 32'd0);
    check("reset stall", 32'(bus.stallreq_for_ex), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    foreach (tbl[i])
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].q, tbl[i].r,
              (i == 0) ? 3 : 0);

    // Flush mid-divide: outputs keep stale values, unit returns to idle.
    bus.div_req    = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort stall", 32'(bus.stallreq_for_ex), 32'd1);
      next_cycle();
    end
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul masks stall", 32'(bus.stallreq_for_ex), 32'd0);
    next_cycle();
    bus.annul   = 1'b0;
    bus.div_req = 1'b0;
    @(negedge clk);
    check("after annul ready", 32'(bus.div_ready), 32'd0);
    check("after annul stall", 32'(bus.stallreq_for_ex), 32'd0);
    check("after annul stale quotient", bus.quotient, last_q);
    check("after annul stale remainder", bus.remainder, last_r);
    next_cycle();
    run_div("post-annul 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);

    // Reset at cycle 20 of a divide.
    bus.div_req    = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd7777;
    bus.divisor    = 32'd5;
    repeat (20) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst         = 1'b1;
    bus.div_req = 1'b0;
    @(negedge clk);
    check("mid reset ready", 32'(bus.div_ready), 32'd0);
    check("mid reset stall", 32'(bus.stallreq_for_ex), 32'd0);
    check("mid reset quotient", bus.quotient, 32'd0);
    check("mid reset remainder", bus.remainder, 32'd0);
    next_cycle();
    run_div("post-reset 7777/5", 32'd7777, 32'd5, 1'b0, 32'd1555, 32'd2, 1);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_div(a, b, sgn, eq, er);
      run_div($sformatf("rand%0d", i), a, b, sgn, eq, er, i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage of the 5-stage pipeline. Serves DIV and DIVU.
- Sits directly upstream of the stall controller. Drives stallreq_for_ex, which the controller turns into a stall vector that freezes IF/ID/EX while the divide runs.
- Returns quotient (to LO) and remainder (to HI) to EX, which forwards them to the HI/LO write path.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration-counter width; must hold WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets.
- div_req  in  1  EX holds a DIV/DIVU; stays high until EX advances.
- div_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_req in IDLE.
- dividend  in  WIDTH  rs operand; sampled in IDLE.
- divisor  in  WIDTH  rt operand; sampled in IDLE.
- annul  in  1  flush of EX (exception/redirect); aborts any divide in progress.
- stallreq_for_ex  out  1  request to the stall controller.
- div_ready  out  1  result valid this cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

Behaviour:
- Reset (rst==0): state=IDLE, counter=0, internal regs=0, div_ready=0, quotient=0, remainder=0.
  - stallreq_for_ex=0, because it is combinational from div_req and state (see rule below) and div_ready=0.
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - If div_req=1 and annul=0: latch operands and signed flag.
    - divisor==0 -> go to ZERO.
    - otherwise -> go to RUN with counter=0.
  - If annul=1: stay in IDLE.
- ZERO (one cycle): load quotient=all-ones, remainder=latched dividend unmodified, then go to DONE.
- RUN: one restoring-division step per cycle on operand magnitudes.
  - Magnitude rule: signed mode takes two's-complement absolute values; unsigned mode uses operands as-is.
  - Partial remainder is WIDTH+1 bits; shift-subtract, compare, restore.
  - counter increments each cycle. After the WIDTH-th step (counter==WIDTH-1), apply sign fixup and go to DONE.
  - Sign fixup (signed mode only): negate quotient if the operand signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 yields quotient=0x8000_0000, remainder=0. No trap.
- DONE:
  - div_ready=1; quotient/remainder registers hold stable.
  - Stay in DONE while div_req=1. Go to IDLE when div_req=0, i.e. the cycle after EX advances.
  - A back-to-back divide (div_req falls for at least one cycle) therefore starts from IDLE.
- stallreq_for_ex = div_req & ~div_ready & ~annul (combinational).
  - It is high from the request cycle through the last RUN/ZERO cycle and low in DONE, so the pipeline advances exactly once per divide.
- Latency:
  - Request seen in IDLE at cycle N -> DONE (div_ready=1) at cycle N+WIDTH+1, i.e. N+33.
  - Divide-by-zero -> div_ready at N+2.
- annul in any state: next state IDLE, counter=0, div_ready=0. Output registers keep their old values and must not be consumed.
  - annul has priority over every other transition.
- rst==0 mid-RUN: same as reset; no partial result escapes.
- div_req dropping mid-RUN without annul is illegal: the pipeline is frozen. It is flagged by an assertion in the bench.
- quotient/remainder change only on the RUN->DONE and ZERO->DONE transitions.

Decomposition:
- Shared package/defines (alongside `StallBus` in defines):
  - state encoding constants DIV_IDLE/DIV_ZERO/DIV_RUN/DIV_DONE (2 bits);
  - DIV_ZERO_QUOT constant (all-ones).
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: {partial remainder, quotient shift reg}, divisor magnitude.
  - Outputs: next partial remainder and next quotient.
- FSM, sign handling and output registers remain in div_unit.

Test Plan:
- Unsigned 100/7:
  - div_req=1, div_signed=0 at cycle 0.
  - stallreq_for_ex=1 for cycles 0..32.
  - Cycle 33: div_ready=1, stallreq_for_ex=0, quotient=14, remainder=2.
- Signed -7/2 (0xFFFF_FFF9 / 2) -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1).
- Signed 7/-2 -> quotient=-3, remainder=1.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0, div_ready at cycle 33.
- Divide-by-zero: 1234/0, signed and unsigned.
  - Cycle 2: div_ready=1, quotient=0xFFFF_FFFF, remainder=1234.
  - stallreq_for_ex high only in cycles 0-1.
- Abort and reset mid-operation:
  - Start 1000/3, pulse annul at cycle 10 -> cycle 11 state=IDLE, stallreq_for_ex=0, div_ready=0.
  - New request 9/3 at cycle 12 -> cycle 45: quotient=3, remainder=0.
  - rst=0 at cycle 20 of a divide -> all outputs 0 the next cycle.
- Back-to-back:
  - Hold div_req=1 in DONE for 3 cycles -> div_ready stays 1, outputs stable.
  - Drop div_req for one cycle -> IDLE.
  - Next request completes with correct result 33 cycles later.
